// File: rtl/fp_mul_sched_if.sv
// Request, multiplier and result signals of the FP multiplier scheduler.
// The slave side is the scheduler; the master side is the surrounding core and multiplier.
interface fp_mul_sched_if #(
  parameter int TAGW = 5
);
  logic            flush;
  logic            req0_valid;
  logic            req0_ready;
  logic [31:0]     req0_a;
  logic [31:0]     req0_b;
  logic [1:0]      req0_rm;
  logic [TAGW-1:0] req0_tag;
  logic            req1_valid;
  logic            req1_ready;
  logic [31:0]     req1_a;
  logic [31:0]     req1_b;
  logic [1:0]      req1_rm;
  logic [TAGW-1:0] req1_tag;
  logic            mul_en;
  logic [31:0]     mul_a;
  logic [31:0]     mul_b;
  logic [1:0]      mul_rm;
  logic [31:0]     mul_s;
  logic            res_valid;
  logic            res_ready;
  logic [31:0]     res_data;
  logic [TAGW-1:0] res_tag;
  logic            res_src;
  logic            busy;

  modport master (
    output flush,
    output req0_valid, req0_a, req0_b, req0_rm, req0_tag,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_rm, req1_tag,
    input  req1_ready,
    input  mul_en, mul_a, mul_b, mul_rm,
    output mul_s,
    input  res_valid, res_data, res_tag, res_src, busy,
    output res_ready
  );

  modport slave (
    input  flush,
    input  req0_valid, req0_a, req0_b, req0_rm, req0_tag,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_rm, req1_tag,
    output req1_ready,
    output mul_en, mul_a, mul_b, mul_rm,
    input  mul_s,
    output res_valid, res_data, res_tag, res_src, busy,
    input  res_ready
  );
endinterface

// File: rtl/fp_mul_sched.sv
// Two-requester round-robin issue scheduler for a shared DEPTH-stage FP multiplier.
// Carries valid/tag/source sideband in lockstep with the multiplier pipe.
module fp_mul_sched #(
  parameter int DEPTH = 3,
  parameter int TAGW  = 5
) (
  input  logic         clk,
  input  logic         rst,
  fp_mul_sched_if.slave io_bus
);

  logic [DEPTH:1]  r_v;
  logic [DEPTH:1]  r_src;
  logic [TAGW-1:0] r_tag [1:DEPTH];
  logic            r_ptr;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [1:0]      r_rm;

  logic            w_advance;
  logic            w_open;
  logic            w_grant0;
  logic            w_grant1;
  logic            w_ready0;
  logic            w_ready1;
  logic            w_issue;
  logic [31:0]     w_mul_a;
  logic [31:0]     w_mul_b;
  logic [1:0]      w_mul_rm;
  logic [TAGW-1:0] w_tag;

  // r_ptr names the requester granted last; the other one wins a tie.
  assign w_advance = ~r_v[DEPTH] | io_bus.res_ready;
  assign w_grant0  = io_bus.req0_valid & (~io_bus.req1_valid | r_ptr);
  assign w_grant1  = io_bus.req1_valid & (~io_bus.req0_valid | ~r_ptr);
  assign w_open    = w_advance & ~io_bus.flush & ~rst;
  assign w_ready0  = w_open & w_grant0;
  assign w_ready1  = w_open & w_grant1;
  assign w_issue   = w_ready0 | w_ready1;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_mul_a  = r_a;
    w_mul_b  = r_b;
    w_mul_rm = r_rm;
    w_tag    = io_bus.req0_tag;
    if (w_ready1) begin
      w_mul_a  = io_bus.req1_a;
      w_mul_b  = io_bus.req1_b;
      w_mul_rm = io_bus.req1_rm;
      w_tag    = io_bus.req1_tag;
    end else if (w_ready0) begin
      w_mul_a  = io_bus.req0_a;
      w_mul_b  = io_bus.req0_b;
      w_mul_rm = io_bus.req0_rm;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v   <= '0;
      r_src <= '0;
      for (int k = 1; k <= DEPTH; k++) r_tag[k] <= '0;
    end else if (io_bus.flush) begin
      r_v <= '0;
    end else if (w_advance) begin
      r_v[1]   <= w_issue;
      r_src[1] <= w_ready1;
      r_tag[1] <= w_tag;
      for (int k = 2; k <= DEPTH; k++) begin
        r_v[k]   <= r_v[k-1];
        r_src[k] <= r_src[k-1];
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  // Last issued operands are held so the multiplier input stays stable across stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b1;
      r_a   <= '0;
      r_b   <= '0;
      r_rm  <= '0;
    end else if (w_issue) begin
      r_ptr <= w_ready1;
      r_a   <= w_mul_a;
      r_b   <= w_mul_b;
      r_rm  <= w_mul_rm;
    end
  end

  assign io_bus.req0_ready = w_ready0;
  assign io_bus.req1_ready = w_ready1;
  assign io_bus.mul_en     = w_advance;
  assign io_bus.mul_a      = w_mul_a;
  assign io_bus.mul_b      = w_mul_b;
  assign io_bus.mul_rm     = w_mul_rm;
  assign io_bus.res_valid  = r_v[DEPTH];
  assign io_bus.res_data   = io_bus.mul_s;
  assign io_bus.res_tag    = r_tag[DEPTH];
  assign io_bus.res_src    = r_src[DEPTH];
  assign io_bus.busy       = |r_v;

endmodule
